// File: rtl/traffic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_pkg : phase encodings, LED codes and config addresses. Rev 1.0
// ---------------------------------------------------------------------------
package traffic_pkg;

  localparam logic [5:0] NS_GREEN  = 6'b000001;
  localparam logic [5:0] NS_YELLOW = 6'b000010;
  localparam logic [5:0] ALLRED_A  = 6'b000100;
  localparam logic [5:0] WE_GREEN  = 6'b001000;
  localparam logic [5:0] WE_YELLOW = 6'b010000;
  localparam logic [5:0] ALLRED_B  = 6'b100000;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [1:0] CFG_NS_GREEN = 2'd0;
  localparam logic [1:0] CFG_WE_GREEN = 2'd1;
  localparam logic [1:0] CFG_YELLOW   = 2'd2;
  localparam logic [1:0] CFG_ALLRED   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/traffic_phase_scheduler_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// phase_timer : per-phase counter with clear, freeze and terminal compare.
// Rev 1.0
// ---------------------------------------------------------------------------
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             freeze,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] dur_eff;

  // A zero duration still occupies one cycle; >= lets a shrinking write exit at once.
  assign dur_eff = (dur == '0) ? CNT_W'(1) : dur;
  assign done    = (count >= (dur_eff - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!freeze) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_phase_scheduler : four-way signal sequencer with ped and EV preempt.
// Rev 1.0
// ---------------------------------------------------------------------------
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GREEN_DEF  = 15,
  parameter int YELLOW_DEF = 3,
  parameter int ALLRED_DEF = 3,
  parameter int MIN_GREEN  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             ped_ns_req,
  input  logic             ped_we_req,
  input  logic             emg_req,
  input  logic             emg_dir,
  output logic [2:0]       led_ns,
  output logic [2:0]       led_we,
  output logic             walk_ns,
  output logic             walk_we,
  output logic             emg_active
);

  logic [5:0]       state;
  logic [5:0]       state_next;
  logic [CNT_W-1:0] green_ns_dur;
  logic [CNT_W-1:0] green_we_dur;
  logic [CNT_W-1:0] yellow_dur;
  logic [CNT_W-1:0] allred_dur;
  logic [CNT_W-1:0] dur;
  logic [CNT_W-1:0] count;
  logic             done;
  logic             min_reached;
  logic             pend_ns;
  logic             pend_we;
  logic             hold;
  logic             release_hold;
  logic             timer_clear;
  logic             emg_active_next;
  logic             ns_entry;
  logic             we_entry;
  logic [5:0]       emg_green;

  always_comb begin
    dur = allred_dur;
    case (state)
      NS_GREEN:             dur = green_ns_dur;
      WE_GREEN:             dur = green_we_dur;
      NS_YELLOW, WE_YELLOW: dur = yellow_dur;
      default:              dur = allred_dur;
    endcase
  end

  assign min_reached = (count >= CNT_W'(MIN_GREEN - 1));
  assign emg_green   = emg_dir ? WE_GREEN : NS_GREEN;

  always_comb begin
    state_next = state;
    case (state)
      NS_GREEN: begin
        // Emergency first; an active hold or its release edge keeps the green.
        if (emg_req && emg_dir)                 state_next = NS_YELLOW;
        else if (emg_req || emg_active)         state_next = NS_GREEN;
        else if (done || (pend_we && min_reached)) state_next = NS_YELLOW;
      end
      NS_YELLOW: if (done) state_next = ALLRED_A;
      ALLRED_A:  if (done) state_next = emg_req ? emg_green : WE_GREEN;
      WE_GREEN: begin
        if (emg_req && !emg_dir)                state_next = WE_YELLOW;
        else if (emg_req || emg_active)         state_next = WE_GREEN;
        else if (done || (pend_ns && min_reached)) state_next = WE_YELLOW;
      end
      WE_YELLOW: if (done) state_next = ALLRED_B;
      ALLRED_B:  if (done) state_next = emg_req ? emg_green : NS_GREEN;
      default:   state_next = NS_GREEN;
    endcase
  end

  assign hold            = emg_req && (state == emg_green);
  assign release_hold    = emg_active && !emg_req;
  assign emg_active_next = emg_req && (state_next == emg_green);
  // Held greens sit at 0 and restart from 0 on release.
  assign timer_clear     = (state_next != state) || release_hold ||
                           (hold && (count != '0));
  assign ns_entry        = (state_next == NS_GREEN) && (state != NS_GREEN);
  assign we_entry        = (state_next == WE_GREEN) && (state != WE_GREEN);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .freeze (hold),
    .dur    (dur),
    .count  (count),
    .done   (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= NS_GREEN;
      green_ns_dur <= CNT_W'(GREEN_DEF);
      green_we_dur <= CNT_W'(GREEN_DEF);
      yellow_dur   <= CNT_W'(YELLOW_DEF);
      allred_dur   <= CNT_W'(ALLRED_DEF);
      pend_ns      <= 1'b0;
      pend_we      <= 1'b0;
      walk_ns      <= 1'b0;
      walk_we      <= 1'b0;
      emg_active   <= 1'b0;
    end else begin
      state      <= state_next;
      emg_active <= emg_active_next;
      pend_ns    <= ped_ns_req | (pend_ns & ~ns_entry);
      pend_we    <= ped_we_req | (pend_we & ~we_entry);
      if (state_next != NS_GREEN) walk_ns <= 1'b0;
      else if (ns_entry)          walk_ns <= pend_ns | ped_ns_req;
      if (state_next != WE_GREEN) walk_we <= 1'b0;
      else if (we_entry)          walk_we <= pend_we | ped_we_req;
      if (cfg_we) begin
        case (cfg_addr)
          CFG_NS_GREEN: green_ns_dur <= cfg_data;
          CFG_WE_GREEN: green_we_dur <= cfg_data;
          CFG_YELLOW:   yellow_dur   <= cfg_data;
          default:      allred_dur   <= cfg_data;
        endcase
      end
    end
  end

  always_comb begin
    led_ns = RED;
    led_we = RED;
    if (state == NS_GREEN)  led_ns = GREEN;
    if (state == NS_YELLOW) led_ns = YELLOW;
    if (state == WE_GREEN)  led_we = GREEN;
    if (state == WE_YELLOW) led_we = YELLOW;
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_traffic_phase_scheduler : scoreboard bench against a phase-level model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_traffic_phase_scheduler;

  localparam int MIN_GREEN = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       ped_ns_req;
  logic       ped_we_req;
  logic       emg_req;
  logic       emg_dir;
  logic [2:0] led_ns;
  logic [2:0] led_we;
  logic       walk_ns;
  logic       walk_we;
  logic       emg_active;

  traffic_phase_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .ped_ns_req (ped_ns_req),
    .ped_we_req (ped_we_req),
    .emg_req    (emg_req),
    .emg_dir    (emg_dir),
    .led_ns     (led_ns),
    .led_we     (led_we),
    .walk_ns    (walk_ns),
    .walk_we    (walk_we),
    .emg_active (emg_active)
  );

  always #5 clk = ~clk;

  // Model: phase index 0..5 = NS green, NS yellow, all-red, WE green, WE yellow, all-red.
  int  mp, me;
  int  mdur [4];
  bit  m_pend [2];
  bit  m_walk [2];
  bit  m_act;

  logic [10:0] exp_q [$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  function automatic int phase_len(int ph);
    int d;
    case (ph)
      0:       d = mdur[0];
      3:       d = mdur[1];
      1, 4:    d = mdur[2];
      default: d = mdur[3];
    endcase
    return (d == 0) ? 1 : d;
  endfunction

  function automatic logic [10:0] model_out();
    logic [2:0] ns, we;
    ns = (mp == 0) ? 3'b001 : (mp == 1) ? 3'b010 : 3'b100;
    we = (mp == 3) ? 3'b001 : (mp == 4) ? 3'b010 : 3'b100;
    return {ns, we, 2'b00, m_walk[0], m_walk[1], m_act};
  endfunction

  task automatic model_reset();
    mp = 0; me = 0;
    mdur[0] = 15; mdur[1] = 15; mdur[2] = 3; mdur[3] = 3;
    m_pend[0] = 0; m_pend[1] = 0;
    m_walk[0] = 0; m_walk[1] = 0;
    m_act = 0;
  endtask

  // One clock of the intersection rules, using the inputs currently driven.
  task automatic model_step();
    int np, gdir;
    bit restart, enter;
    bit req [2];
    req[0] = ped_ns_req;
    req[1] = ped_we_req;
    np = mp;
    restart = 0;
    if (mp == 0 || mp == 3) begin
      gdir = (mp == 3) ? 1 : 0;
      if (emg_req && (int'(emg_dir) != gdir)) np = mp + 1;
      else if (emg_req || m_act) restart = 1;
      else if (me + 1 >= phase_len(mp)) np = mp + 1;
      else if (m_pend[1 - gdir] && me + 1 >= MIN_GREEN) np = mp + 1;
    end else if (me + 1 >= phase_len(mp)) begin
      if (mp == 2 || mp == 5) np = emg_req ? (emg_dir ? 3 : 0) : (mp + 1) % 6;
      else np = mp + 1;
    end
    for (int k = 0; k < 2; k++) begin
      enter = (np == 3 * k) && (mp != 3 * k);
      if (np != 3 * k) m_walk[k] = 0;
      else if (enter)  m_walk[k] = m_pend[k] | req[k];
      m_pend[k] = req[k] | (m_pend[k] & !enter);
    end
    m_act = emg_req && (np == (emg_dir ? 3 : 0));
    me = (np != mp || restart) ? 0 : me + 1;
    mp = np;
    if (cfg_we) mdur[cfg_addr] = int'(cfg_data);
  endtask

  always @(negedge clk) begin
    logic [10:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {led_ns, led_we, 2'b00, walk_ns, walk_we, emg_active};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL outputs @cycle %0d: got ns=%b we=%b walk=%b%b emg=%b, want ns=%b we=%b walk=%b%b emg=%b",
                 cyc, g[10:8], g[7:5], g[2], g[1], g[0], e[10:8], e[7:5], e[2], e[1], e[0]);
      end
    end
  end

  task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d,
                      input logic pn, input logic pw, input logic em, input logic ed);
    cfg_we = w; cfg_addr = a; cfg_data = d;
    ped_ns_req = pn; ped_we_req = pw; emg_req = em; emg_dir = ed;
    @(posedge clk);
    #2;
    cyc++;
    model_step();
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 8'd0, 0, 0, 0, 0);
  endtask

  task automatic steer(input int tp, input int te);
    for (int i = 0; i < 300; i++) begin
      if (mp == tp && (te < 0 || me == te)) return;
      step(0, 2'd0, 8'd0, 0, 0, 0, 0);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL steer: model never reached phase %0d count %0d", tp, te);
  endtask

  task automatic reset_mid();
    cfg_we = 0; ped_ns_req = 0; ped_we_req = 0; emg_req = 0; emg_dir = 0;
    @(posedge clk);
    #2;
    cyc++;
    model_step();
    #1 rst_n = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic em, ed;
    rst_n = 1'b0;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    ped_ns_req = 0; ped_we_req = 0; emg_req = 0; emg_dir = 0;
    model_reset();
    #3 exp_q.push_back(model_out());
    @(negedge clk);
    #1 rst_n = 1'b1;

    idle(100);
    steer(3, -1);                      // ped NS during WE green
    step(0, 2'd0, 8'd0, 1, 0, 0, 0);
    idle(60);
    steer(0, 2);                       // ped WE shortens NS green
    step(0, 2'd0, 8'd0, 0, 1, 0, 0);
    idle(50);
    steer(0, 3);                       // emergency towards WE
    for (int i = 0; i < 50; i++) step(0, 2'd0, 8'd0, 0, 0, 1, 1);
    idle(50);
    steer(0, -1);
    step(1, 2'd2, 8'd5, 0, 0, 0, 0);
    idle(50);
    step(1, 2'd2, 8'd0, 0, 0, 0, 0);
    idle(50);
    step(1, 2'd2, 8'd3, 0, 0, 0, 0);
    steer(0, 8);
    step(1, 2'd0, 8'd2, 0, 0, 0, 0);
    idle(30);
    step(1, 2'd0, 8'd15, 0, 0, 0, 0);
    steer(0, 4);                       // emergency held, then direction flips
    for (int i = 0; i < 10; i++) step(0, 2'd0, 8'd0, 0, 0, 1, 0);
    for (int i = 0; i < 30; i++) step(0, 2'd0, 8'd0, 0, 0, 1, 1);
    idle(20);

    em = 0; ed = 0;
    for (int i = 0; i < 3000; i++) begin
      logic w;
      if ($urandom_range(0, 199) == 0) begin
        em = ~em;
        ed = 1'($urandom_range(0, 1));
      end
      w = ($urandom_range(0, 59) == 0);
      step(w, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 20)),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0), em, ed);
    end
    step(1, 2'd0, 8'd15, 0, 0, 0, 0);
    step(1, 2'd1, 8'd15, 0, 0, 0, 0);
    step(1, 2'd2, 8'd3, 0, 0, 0, 0);
    step(1, 2'd3, 8'd3, 0, 0, 0, 0);
    idle(60);

    steer(3, -1);                      // reset in WE yellow with latches set
    step(1, 2'd2, 8'd9, 1, 1, 0, 0);
    steer(4, 2);
    reset_mid();
    idle(100);

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
